// File: rtl/btn_conditioner_pkg.sv
// Shared types, default timing constants and sizing helper for the pushbutton conditioner.
// Optional feature macro: BTN_CONDITIONER_AUTO_REPEAT_EN (see btn_channel / btn_conditioner).
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  // 10 ms debounce, 500 ms to first repeat, 100 ms between repeats at 100 MHz.
  localparam int DEF_DB_CYCLES  = 1_000_000;
  localparam int DEF_RPT_DELAY  = 50_000_000;
  localparam int DEF_RPT_PERIOD = 10_000_000;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bus: raw board inputs in, debounced level and press/release pulses out.
// The conditioner takes the slave side; whoever drives the buttons takes the master side.
interface btn_conditioner_if #(
  parameter int CH = 5
);

  logic [CH-1:0] btn_conditioner_raw;
  logic [CH-1:0] btn_conditioner_level;
  logic [CH-1:0] btn_conditioner_press;
  logic [CH-1:0] btn_conditioner_release;

  modport master (
    output btn_conditioner_raw,
    input  btn_conditioner_level,
    input  btn_conditioner_press,
    input  btn_conditioner_release
  );

  modport slave (
    input  btn_conditioner_raw,
    output btn_conditioner_level,
    output btn_conditioner_press,
    output btn_conditioner_release
  );

endinterface

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM with saturating-by-construction counter.
// With BTN_CONDITIONER_AUTO_REPEAT_EN defined, a repeat counter re-pulses press while held.
module btn_channel
  import btn_conditioner_pkg::*;
#(
  parameter int DB_CYCLES  = DEF_DB_CYCLES,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic sync1;
  logic s;
  btn_state_t state;
  logic [CW-1:0] cnt;

`ifdef BTN_CONDITIONER_AUTO_REPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW = cnt_width(RPT_MAX);
  localparam logic [RW-1:0] RPT_FIRST = RW'(RPT_DELAY - 1);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(RPT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_phase;
`else
  // Repeat timing is not built here; this empty check only keeps the parameter list uniform.
  if (RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_rpt_ignored
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  // The counter only increments below CNT_LAST, since reaching it always forces a state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
`ifdef BTN_CONDITIONER_AUTO_REPEAT_EN
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
`endif
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= PRESSED;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
`ifdef BTN_CONDITIONER_AUTO_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
`endif
          end
`ifdef BTN_CONDITIONER_AUTO_REPEAT_EN
          else if (rpt_cnt == (rpt_phase ? RPT_NEXT : RPT_FIRST)) begin
            press     <= 1'b1;
            rpt_cnt   <= '0;
            rpt_phase <= 1'b1;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
`endif
        end
        RELEASE_WAIT: begin
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            rel   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner top: CH independent synchronise/debounce channels on one clock.
// Optional macro BTN_CONDITIONER_AUTO_REPEAT_EN enables press auto-repeat while held.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int CH         = 5,
  parameter int DB_CYCLES  = DEF_DB_CYCLES,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
  input  logic               btn_conditioner_clk,
  input  logic               btn_conditioner_rst,
  btn_conditioner_if.slave   btn_conditioner_bus
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    btn_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .RPT_DELAY  (RPT_DELAY),
      .RPT_PERIOD (RPT_PERIOD)
    ) u_channel (
      .clk   (btn_conditioner_clk),
      .rst   (btn_conditioner_rst),
      .raw   (btn_conditioner_bus.btn_conditioner_raw[i]),
      .level (btn_conditioner_bus.btn_conditioner_level[i]),
      .press (btn_conditioner_bus.btn_conditioner_press[i]),
      .rel   (btn_conditioner_bus.btn_conditioner_release[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus random button activity,
// compared every cycle against a window-based behavioural model (honours BTN_CONDITIONER_AUTO_REPEAT_EN).
module tb_btn_conditioner;

  localparam int CH = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int HL = DB + 3;

  logic clk = 1'b0;
  logic rst;

  btn_conditioner_if #(.CH(CH)) bus ();

  btn_conditioner #(
    .CH         (CH),
    .DB_CYCLES  (DB),
    .RPT_DELAY  (RD),
    .RPT_PERIOD (RP)
  ) dut (
    .btn_conditioner_clk (clk),
    .btn_conditioner_rst (rst),
    .btn_conditioner_bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // hist[c][k] holds the raw value sampled k edges ago; the FSM acts on the one 2 edges old.
  bit          hist [CH][HL];
  bit          lvl_m [CH];
  int          age_m [CH];
  bit [CH-1:0] exp_level;
  bit [CH-1:0] exp_press;
  bit [CH-1:0] exp_rel;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // A level flips once DB+1 consecutive synchronised samples all disagree with it.
  task automatic modelStep(input bit rst_v, input bit [CH-1:0] raw_v);
    bit all_diff;
    bit s_now;
    bit s_prev;
    exp_press = '0;
    exp_rel   = '0;
    for (int c = 0; c < CH; c++) begin
      if (rst_v) begin
        for (int j = 0; j < HL; j++) hist[c][j] = 1'b0;
        lvl_m[c] = 1'b0;
        age_m[c] = 0;
      end else begin
        for (int j = HL - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
        hist[c][0] = raw_v[c];
        s_now  = hist[c][2];
        s_prev = hist[c][3];
        all_diff = 1'b1;
        for (int j = 2; j <= DB + 2; j++) if (hist[c][j] == lvl_m[c]) all_diff = 1'b0;
        if (all_diff) begin
          if (!lvl_m[c]) begin
            lvl_m[c]     = 1'b1;
            exp_press[c] = 1'b1;
            age_m[c]     = 0;
          end else begin
            lvl_m[c]   = 1'b0;
            exp_rel[c] = 1'b1;
          end
        end else if (lvl_m[c] && s_now) begin
          if (!s_prev) begin
            age_m[c] = 0;
          end else begin
            age_m[c]++;
`ifdef BTN_CONDITIONER_AUTO_REPEAT_EN
            if (age_m[c] == RD || (age_m[c] > RD && (age_m[c] - RD) % RP == 0)) exp_press[c] = 1'b1;
`endif
          end
        end
      end
      exp_level[c] = lvl_m[c];
    end
  endtask

  task automatic applyStimulus(input bit rst_v, input bit [CH-1:0] raw_v);
    rst = rst_v;
    bus.btn_conditioner_raw = raw_v;
    @(posedge clk);
    #1;
    modelStep(rst_v, raw_v);
    checkOutput("level",   32'(bus.btn_conditioner_level),   32'(exp_level));
    checkOutput("press",   32'(bus.btn_conditioner_press),   32'(exp_press));
    checkOutput("release", 32'(bus.btn_conditioner_release), 32'(exp_rel));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0);
  endtask

  initial begin
    int          first;
    int          second;
    int          count;
    int          hold [CH];
    bit [CH-1:0] rnd_raw;
    bit          rnd_rst;

    rst = 1'b1;
    bus.btn_conditioner_raw = '0;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'b11);
      checkOutput("rst_outputs", {26'd0, bus.btn_conditioner_level, bus.btn_conditioner_press,
                                  bus.btn_conditioner_release}, 32'd0);
    end
    applyStimulus(1'b0, 2'b00);
    checkOutput("post_rst_outputs", {26'd0, bus.btn_conditioner_level, bus.btn_conditioner_press,
                                     bus.btn_conditioner_release}, 32'd0);
    idleCycles(8);

    first = -1; count = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 2'b01);
      if (bus.btn_conditioner_press[0]) begin
        count++;
        if (first < 0) first = i;
      end
    end
    checkOutput("press_latency", first, 6);
    checkOutput("press_count", count, 1);
    checkOutput("level_after_press", 32'(bus.btn_conditioner_level[0]), 1);

    first = -1; count = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 2'b00);
      if (bus.btn_conditioner_release[0]) begin
        count++;
        if (first < 0) first = i;
      end
    end
    checkOutput("release_latency", first, 6);
    checkOutput("release_count", count, 1);
    checkOutput("level_after_release", 32'(bus.btn_conditioner_level[0]), 0);

    first = -1; count = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, (i < 4) ? 2'(~i & 1) : 2'b01);
      if (bus.btn_conditioner_press[0]) begin
        count++;
        if (first < 0) first = i;
      end
    end
    checkOutput("toggle_press_cycle", first, 10);
    checkOutput("toggle_press_count", count, 1);

    count = 0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b0, (i < 3) ? 2'b00 : 2'b01);
      if (bus.btn_conditioner_release[0]) count++;
    end
    checkOutput("glitch_release_count", count, 0);
    checkOutput("glitch_level", 32'(bus.btn_conditioner_level[0]), 1);
    idleCycles(10);

    first = -1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 2'b11);
      if (bus.btn_conditioner_press == 2'b11 && first < 0) first = i;
    end
    checkOutput("dual_press_cycle", first, 6);
    idleCycles(10);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b01);
    applyStimulus(1'b1, 2'b01);
    first = -1; count = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 2'b01);
      if (bus.btn_conditioner_press[0]) begin
        count++;
        if (first < 0) first = i;
      end
    end
    checkOutput("reset_restart_cycle", first, 6);
    checkOutput("reset_restart_count", count, 1);
    idleCycles(10);

    first = -1; second = -1; count = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 2'b10);
      if (bus.btn_conditioner_press[1]) begin
        count++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    checkOutput("hold_first_press", first, 6);
`ifdef BTN_CONDITIONER_AUTO_REPEAT_EN
    checkOutput("hold_first_repeat", second, 16);
    checkOutput("hold_press_count", count, 3);
`else
    checkOutput("hold_press_count", count, 1);
`endif
    idleCycles(10);

    for (int c = 0; c < CH; c++) hold[c] = 0;
    rnd_raw = '0;
    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          rnd_raw[c] = 1'($urandom_range(0, 1));
          hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 24)) : int'($urandom_range(1, 7));
        end
        hold[c]--;
      end
      rnd_rst = ($urandom_range(0, 79) == 0);
      applyStimulus(rnd_rst, rnd_raw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
